// File: rtl/dip_pkg.sv
// Shared types and constants for the DIP colour-space converter.
// Coefficients are 8-bit fixed-point magnitudes. The chroma signs are applied in the adder tree.
package dip_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_YCC422 = 2'd2,
    MODE_BIN    = 2'd3
  } mode_t;

  localparam int COEF_YR  = 77;
  localparam int COEF_YG  = 150;
  localparam int COEF_YB  = 29;
  localparam int COEF_CBR = 43;
  localparam int COEF_CBG = 85;
  localparam int COEF_CBB = 128;
  localparam int COEF_CRR = 128;
  localparam int COEF_CRG = 107;
  localparam int COEF_CRB = 21;

  // Chroma zero point, before scaling by 2^FRAC_W
  localparam int CHROMA_OFS = 128;

  typedef struct packed {
    logic        vld;
    logic        sof;
    logic        phase;
    mode_t       mode;
    logic [7:0]  thresh;
    logic [15:0] pix;
  } side_t;

  function automatic logic [7:0] sat8(input logic signed [23:0] v);
    if (v < 0) begin
      return 8'd0;
    end else if (v > 24'sd255) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/dip_csc_pipe_if.sv
// Pixel stream bundle: camera-side pixels and config in, SDRAM-write pixels out.
interface dip_csc_pipe_if;
  logic        dip_en;
  logic [15:0] dip_data;
  logic        dip_sof;
  logic        dip_sol;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_thresh;
  logic [15:0] sdram_wr_data;
  logic        sdram_wr_en;
  logic        sdram_wr_sof;

  modport master (
    output dip_en, dip_data, dip_sof, dip_sol, cfg_mode, cfg_thresh,
    input  sdram_wr_data, sdram_wr_en, sdram_wr_sof
  );

  modport slave (
    input  dip_en, dip_data, dip_sof, dip_sol, cfg_mode, cfg_thresh,
    output sdram_wr_data, sdram_wr_en, sdram_wr_sof
  );
endinterface

// File: rtl/dip_rgb565_to_ycbcr.sv
// RGB565 to YCbCr arithmetic with two register stages.
// S1 holds the nine channel products. S2 holds the rounded, shifted and saturated results.
module dip_rgb565_to_ycbcr
  import dip_pkg::*;
#(
  parameter int FRAC_W = 8
) (
  input  logic        clk,
  input  logic [15:0] rgb,
  output logic [7:0]  y,
  output logic [7:0]  cb,
  output logic [7:0]  cr
);

  localparam int SH = FRAC_W - 8;
  localparam logic [19:0] K [9] = '{
    20'(COEF_YR  << SH), 20'(COEF_YG  << SH), 20'(COEF_YB  << SH),
    20'(COEF_CBR << SH), 20'(COEF_CBG << SH), 20'(COEF_CBB << SH),
    20'(COEF_CRR << SH), 20'(COEF_CRG << SH), 20'(COEF_CRB << SH)
  };
  localparam logic signed [23:0] RND = 24'(1 << (FRAC_W - 1));
  localparam logic signed [23:0] OFS = 24'(CHROMA_OFS << FRAC_W);

  logic [7:0]         ch [3];
  logic [19:0]        prod_reg [9];
  logic signed [23:0] ext [9];
  logic signed [23:0] y_sum, cb_sum, cr_sum;

  // Replicate the top bits into the low bits so that full scale maps to 255
  always_comb begin
    ch[0] = {rgb[15:11], rgb[15:13]};
    ch[1] = {rgb[10:5],  rgb[10:9]};
    ch[2] = {rgb[4:0],   rgb[4:2]};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 9; i++) begin
      prod_reg[i] <= 20'(ch[i % 3]) * K[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      ext[i] = {4'b0000, prod_reg[i]};
    end
    y_sum  = ext[0] + ext[1] + ext[2] + RND;
    cb_sum = OFS + RND + ext[5] - ext[3] - ext[4];
    cr_sum = OFS + RND + ext[6] - ext[7] - ext[8];
  end

  always_ff @(posedge clk) begin
    y  <= sat8(y_sum  >>> FRAC_W);
    cb <= sat8(cb_sum >>> FRAC_W);
    cr <= sat8(cr_sum >>> FRAC_W);
  end

endmodule

// File: rtl/dip_csc_pipe.sv
// Mode-selectable colour-space converter with a fixed 3-cycle latency.
// Config and phase are captured per pixel and travel with it down a valid-tagged shift pipe.
module dip_csc_pipe
  import dip_pkg::*;
#(
  parameter int         FRAC_W     = 8,
  parameter logic [1:0] DEF_MODE   = 2'd1,
  parameter logic [7:0] DEF_THRESH = 8'd128
) (
  input logic         pclk,
  input logic         rst_n,
  dip_csc_pipe_if.slave bus
);

  mode_t       mode_reg;
  logic [7:0]  thresh_reg;
  logic        phase_reg;
  side_t       side_in;
  logic [7:0]  y, cb, cr;
  logic [15:0] data_reg, data_next;
  logic        en_reg, sof_reg;

  // SOF config takes effect on the SOF pixel itself, so bypass the latch here
  always_comb begin
    side_in        = '0;
    side_in.vld    = bus.dip_en;
    side_in.sof    = bus.dip_en && bus.dip_sof;
    side_in.phase  = (bus.dip_sol || bus.dip_sof) ? 1'b0 : phase_reg;
    side_in.mode   = side_in.sof ? mode_t'(bus.cfg_mode) : mode_reg;
    side_in.thresh = side_in.sof ? bus.cfg_thresh : thresh_reg;
    side_in.pix    = bus.dip_data;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      mode_reg   <= mode_t'(DEF_MODE);
      thresh_reg <= DEF_THRESH;
      phase_reg  <= 1'b0;
    end else if (bus.dip_en) begin
      mode_reg   <= side_in.mode;
      thresh_reg <= side_in.thresh;
      phase_reg  <= ~side_in.phase;
    end
  end

  dip_rgb565_to_ycbcr #(.FRAC_W(FRAC_W)) u_csc (
    .clk (pclk),
    .rgb (bus.dip_data),
    .y   (y),
    .cb  (cb),
    .cr  (cr)
  );

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_side
    side_t st_reg;
    side_t st_src;
    if (gi == 0) begin : g_head
      assign st_src = side_in;
    end else begin : g_tail
      assign st_src = g_side[gi-1].st_reg;
    end
    always_ff @(posedge pclk) begin
      if (!rst_n) begin
        st_reg <= '0;
      end else begin
        st_reg <= st_src;
      end
    end
  end

  always_comb begin
    data_next = g_side[1].st_reg.pix;
    unique case (g_side[1].st_reg.mode)
      MODE_BYPASS: data_next = g_side[1].st_reg.pix;
      MODE_GRAY:   data_next = {y[7:3], y[7:2], y[7:3]};
      MODE_YCC422: data_next = g_side[1].st_reg.phase ? {y, cr} : {y, cb};
      MODE_BIN:    data_next = (y >= g_side[1].st_reg.thresh) ? 16'hFFFF : 16'h0000;
      default:     data_next = g_side[1].st_reg.pix;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      en_reg   <= 1'b0;
      sof_reg  <= 1'b0;
      data_reg <= 16'h0000;
    end else begin
      en_reg  <= g_side[1].st_reg.vld;
      sof_reg <= g_side[1].st_reg.vld && g_side[1].st_reg.sof;
      if (g_side[1].st_reg.vld) begin
        data_reg <= data_next;
      end
    end
  end

  assign bus.sdram_wr_data = data_reg;
  assign bus.sdram_wr_en   = en_reg;
  assign bus.sdram_wr_sof  = sof_reg;

endmodule

// File: tb/tb_dip_csc_pipe.sv
// Scoreboard bench for dip_csc_pipe. Expected pixels are queued at drive time and matched on output.
module tb_dip_csc_pipe;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    int          cyc;
  } exp_t;

  logic pclk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  logic [1:0] mdl_mode;
  logic [7:0] mdl_thr;
  logic       mdl_ph;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  dip_csc_pipe_if bus();

  dip_csc_pipe #(.FRAC_W(8), .DEF_MODE(2'd1), .DEF_THRESH(8'd128)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] m,
                                        input logic [7:0] th, input logic ph);
    int r, g, b, yi, cbi, cri;
    logic [7:0] yv, cbv, crv;
    r   = d[15:11] * 8 + d[15:13];
    g   = d[10:5] * 4 + d[10:9];
    b   = d[4:0] * 8 + d[4:2];
    yi  = (77 * r + 150 * g + 29 * b + 128) / 256;
    cbi = (32896 + 128 * b - 43 * r - 85 * g) / 256;
    cri = (32896 + 128 * r - 107 * g - 21 * b) / 256;
    yv  = (yi  > 255) ? 8'hFF : yi[7:0];
    cbv = (cbi > 255) ? 8'hFF : cbi[7:0];
    crv = (cri > 255) ? 8'hFF : cri[7:0];
    case (m)
      2'd0:    return d;
      2'd1:    return {yv[7:3], yv[7:2], yv[7:3]};
      2'd2:    return ph ? {yv, crv} : {yv, cbv};
      default: return (yv >= th) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic px(input logic en, input logic [15:0] d, input logic sof, input logic sol,
                    input logic [1:0] m, input logic [7:0] th,
                    input logic use_k = 1'b0, input logic [15:0] k = 16'h0000);
    logic ph;
    exp_t e;
    @(negedge pclk);
    bus.dip_en     = en;
    bus.dip_data   = d;
    bus.dip_sof    = sof;
    bus.dip_sol    = sol;
    bus.cfg_mode   = m;
    bus.cfg_thresh = th;
    if (en) begin
      if (sof) begin
        mdl_mode = m;
        mdl_thr  = th;
      end
      ph     = (sof || sol) ? 1'b0 : mdl_ph;
      mdl_ph = ~ph;
      e.data = use_k ? k : model(d, mdl_mode, mdl_thr, ph);
      e.sof  = sof;
      e.cyc  = cyc + 3;
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst_n      = 1'b0;
    bus.dip_en = 1'b0;
    @(posedge pclk);
    #1;
    q.delete();
    mdl_mode = 2'd1;
    mdl_thr  = 8'd128;
    mdl_ph   = 1'b0;
    check("rst_en",   {31'd0, bus.sdram_wr_en},  32'd0);
    check("rst_sof",  {31'd0, bus.sdram_wr_sof}, 32'd0);
    check("rst_data", {16'd0, bus.sdram_wr_data}, 32'd0);
    @(negedge pclk);
    rst_n = 1'b1;
  endtask

  always @(negedge pclk) begin
    if (bus.sdram_wr_en) begin
      if (q.size() == 0) begin
        check("spurious_en", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("px cyc=%0d data=%h sof=%b exp=%h", cyc, bus.sdram_wr_data, bus.sdram_wr_sof, e.data);
        check("data",    {16'd0, bus.sdram_wr_data}, {16'd0, e.data});
        check("sof",     {31'd0, bus.sdram_wr_sof},  {31'd0, e.sof});
        check("latency", cyc, e.cyc);
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      void'(q.pop_front());
      check("missing_en", 32'd0, 32'd1);
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.dip_en     = 1'b0;
    bus.dip_data   = 16'h0000;
    bus.dip_sof    = 1'b0;
    bus.dip_sol    = 1'b0;
    bus.cfg_mode   = 2'd0;
    bus.cfg_thresh = 8'd0;
    do_reset();

    // White in gray mode, then an idle gap
    px(1, 16'hFFFF, 1, 0, 2'd1, 8'd128, 1, 16'hFFFF);
    repeat (4) px(0, 16'h0000, 0, 0, 2'd0, 8'd0);

    // Red and blue in 4:2:2, including chroma saturation
    px(1, 16'hF800, 1, 1, 2'd2, 8'd0, 1, 16'h4D55);
    px(1, 16'hF800, 0, 0, 2'd2, 8'd0, 1, 16'h4DFF);
    px(1, 16'h001F, 0, 1, 2'd2, 8'd0, 1, 16'h1DFF);
    px(1, 16'h001F, 0, 0, 2'd2, 8'd0, 1, 16'h1D6B);

    // Binary threshold at the Y boundary
    px(1, 16'hF800, 1, 0, 2'd3, 8'd77, 1, 16'hFFFF);
    px(1, 16'hF800, 1, 0, 2'd3, 8'd78, 1, 16'h0000);

    // A config change without SOF is ignored until the next frame
    px(1, 16'h1234, 1, 0, 2'd1, 8'd0);
    px(1, 16'h1234, 0, 0, 2'd0, 8'd0, 1, 16'h4208);
    px(1, 16'h1234, 1, 0, 2'd0, 8'd0, 1, 16'h1234);

    // Alternating valid in 4:2:2
    for (int i = 0; i < 12; i++) begin
      px((i % 2) == 0, 16'h8421 + 16'(i * 97), i == 0, 0, 2'd2, 8'd0);
    end

    // Random traffic; SOF without dip_en must not latch the config
    for (int i = 0; i < 60; i++) begin
      px($urandom_range(9, 0) < 7, 16'($urandom), $urandom_range(7, 0) == 0,
         $urandom_range(4, 0) == 0, 2'($urandom), 8'($urandom));
    end

    // Reset with pixels in flight, then the default mode applies
    px(1, 16'hABCD, 1, 0, 2'd0, 8'd0);
    px(1, 16'h5555, 0, 0, 2'd0, 8'd0);
    px(1, 16'h7777, 0, 0, 2'd0, 8'd0);
    do_reset();
    px(1, 16'h1234, 0, 0, 2'd0, 8'd0, 1, 16'h4208);
    px(1, 16'hF800, 0, 0, 2'd3, 8'd0);

    repeat (8) px(0, 16'h0000, 0, 0, 2'd0, 8'd0);
    check("drain", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dip_csc_pipe.md
# dip_csc_pipe

Parametrised, mode-selectable colour-space converter for the DIP path: OV5640 RGB565 pixels in, SDRAM-write pixels out. It generalises the fixed RGB565→Y converter into four frame-latched modes:

- RGB565 bypass
- grayscale
- packed YCbCr 4:2:2
- Y-threshold binary

It keeps fixed, gap-tolerant pipeline latency and has programmable arithmetic precision and defaults. It sits between camera capture and the SDRAM write FIFO, ahead of the Sobel/erode/dilate stages.

## Interface
Parameters:
- FRAC_W, 8: fractional bits of the luma/chroma coefficients; legal range 8..12. Coefficients are the 8-bit values below shifted left by (FRAC_W-8).
- DEF_MODE, 2'd1: mode in effect after reset.
- DEF_THRESH, 8'd128: binary threshold after reset.

Ports:
- pclk, input, 1: pixel clock; the only clock.
- rst_n, input, 1: synchronous, active-low reset, sampled on the pclk rising edge.
- dip_en, input, 1: input pixel valid; may be asserted on any subset of cycles.
- dip_data, input, 16: RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
- dip_sof, input, 1: first pixel of frame; qualified by dip_en.
- dip_sol, input, 1: first pixel of line; qualified by dip_en.
- cfg_mode, input, 2: 0 = bypass, 1 = gray, 2 = YCbCr422, 3 = binary.
- cfg_thresh, input, 8: binary threshold on Y.
- sdram_wr_data, output, 16: converted pixel.
- sdram_wr_en, output, 1: output valid.
- sdram_wr_sof, output, 1: dip_sof delayed and aligned with its pixel.

## Operation
- **Expansion.** R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- **Arithmetic** (shown for FRAC_W=8; signed intermediates at least 20 bits wide):
  - Y = (77R+150G+29B+128)>>8
  - Cb = (−43R−85G+128B+32896)>>8
  - Cr = (128R−107G−21B+32896)>>8
  - For general FRAC_W, the rounding constant is 2^(FRAC_W−1) and the offset is 128·2^FRAC_W; the shift is FRAC_W.
  - Each result saturates to 0..255 (for example, 256 becomes 255).
- **Config latch.** When dip_en && dip_sof, the active mode and threshold are loaded from cfg_mode and cfg_thresh. They apply to that pixel and to every pixel after it. cfg changes at any other time are ignored until the next SOF.
- **Mode outputs:**
  - bypass: dip_data unchanged.
  - gray: {Y[7:3],Y[7:2],Y[7:3]}.
  - YCbCr422: on an even-phase pixel, {Y,Cb}; on an odd-phase pixel, {Y,Cr}. Chroma is taken from the current pixel and is not averaged.
  - binary: 16'hFFFF if Y ≥ thresh, otherwise 16'h0000.
- **Phase bit.** It toggles on every valid pixel. When dip_en && (dip_sol || dip_sof), it is forced to even for that pixel. The phase, mode and threshold travel down the pipe with their pixel.
- **Pipeline.** It is a free-running shift pipeline with a valid bit per stage. Gaps in dip_en propagate as gaps on sdram_wr_en. There is no back-pressure.

## Timing
- **Latency.** Exactly 3 pclk cycles from a dip_en sample to sdram_wr_en, in every mode (bypass is delayed to match):
  - S1: channel expansion and products.
  - S2: sums, shift and saturation.
  - S3: mode mux into the output register.
- **Throughput.** One pixel per cycle; back-to-back dip_en is supported.
- **Reset values:**
  - sdram_wr_en=0, sdram_wr_sof=0, sdram_wr_data=16'h0000.
  - Every stage valid bit is cleared.
  - Mode=DEF_MODE, threshold=DEF_THRESH, phase=even.
- **Reset mid-frame.** All in-flight pixels are dropped, and no sdram_wr_en is produced for them.
- **SOF and SOL on the same pixel.** Phase is even and the config latches.
- **SOF without dip_en.** Ignored.

## Structure
- **Shared package dip_pkg:**
  - mode constants MODE_BYPASS, MODE_GRAY, MODE_YCC422, MODE_BIN
  - the 8-bit coefficient constants
  - the chroma offset constant
- **Sub-module dip_rgb565_to_ycbcr.** It implements the S1/S2 arithmetic (expansion, multiply, round, saturate) with a 2-cycle latency, parametrised by FRAC_W.
- **Top level.** It holds the config latch, the phase logic, the sideband delay line and the S3 output mux.

## Test plan
1. **White, gray mode.** Reset with DEF_MODE=1, then drive dip_data=16'hFFFF with SOF. Expect sdram_wr_data=16'hFFFF with sdram_wr_en exactly 3 cycles later; Y=255, Cb=Cr=128.
2. **Red, 4:2:2 mode.** Drive 16'hF800 in mode 2 with SOL on the first pixel, two pixels. Expect 16'h4D55 then 16'h4DFF (Y=77, Cb=85, Cr saturated 256→255). Blue 16'h001F gives Cb saturated at 255 and Y=29.
3. **Binary threshold.** In mode 3, drive red with thresh=77 latched at SOF. Expect 16'hFFFF. In the next frame set thresh=78 and expect 16'h0000.
4. **Mid-frame config change.** Change cfg_mode from 1 to 0 mid-frame. Output stays gray until the next SOF, then bypass passes 16'h1234 as 16'h1234.
5. **Alternating dip_en.** Toggle dip_en every other cycle (incrementing data). The output valid pattern matches the input pattern shifted by 3 cycles, and the 4:2:2 phase advances only on valid pixels.
6. **Mid-stream reset.** Assert rst_n=0 for one cycle mid-stream. The following cycles show no sdram_wr_en for in-flight pixels, and the mode reverts to DEF_MODE.
